xm_mem_unit: RTL

// Parametrised memory-access unit for the X-Makina multi-cycle core; takes over the MAR/OMDR path of
// the datapath. Accepts one load/store from the control unit, checks alignment, steers byte lanes,

---
 rtl/xm_pkg.sv | 17 +
 rtl/xm_byte_lane.sv | 42 ++++
 rtl/xm_mem_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/xm_pkg.sv
// Shared types and constants for the X-Makina memory-access unit.
package xm_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } mem_state_t;

  // Fault codes reported on faultCode_o
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/xm_byte_lane.sv
// Byte-lane steering: byte enables, write-data replication and read-data
// extraction with zero/sign extension. Purely combinational.
module xm_byte_lane #(
  parameter int WORD = 16
) (
  input  logic [$clog2(WORD/8)-1:0] lane,
  input  logic                      byte_op,
  input  logic                      sign_ext,
  input  logic [WORD-1:0]           wdata,
  input  logic [WORD-1:0]           bus_rdata,
  output logic [WORD/8-1:0]         be,
  output logic [WORD-1:0]           wdat,
  output logic [WORD-1:0]           rdat
);
  import xm_pkg::*;

  localparam int BYTES = WORD / 8;

  // Widen one byte to a full word, copying bit 7 upward when sign-extending
  function automatic logic [WORD-1:0] extend_byte(input logic [7:0] b, input logic sx);
    logic signed [WORD-1:0] ext_s;
    ext_s = sx ? {{(WORD-8){b[7]}}, b} : {{(WORD-8){1'b0}}, b};
    return ext_s;
  endfunction

  logic [7:0] lane_byte;

  // Lane selection for enables, store replication and load extraction
  always_comb begin
    lane_byte = bus_rdata[8*lane +: 8];
    if (byte_op) begin
      be   = BYTES'(1) << lane;
      wdat = {BYTES{wdata[7:0]}};
      rdat = extend_byte(lane_byte, sign_ext);
    end else begin
      be   = '1;
      wdat = wdata;
      rdat = bus_rdata;
    end
  end

endmodule

// File: rtl/xm_mem_unit.sv
// Memory-access unit: accepts one load/store, checks alignment, runs a
// req/ack bus cycle with a wait-state timeout and returns extended read data.
module xm_mem_unit #(
  parameter int WORD    = 16,
  parameter int BYTES   = WORD / 8,
  parameter int TIMEOUT = 16
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic                            req_i,
  input  logic                            write_i,
  input  logic                            byteOp_i,
  input  logic                            signExt_i,
  input  logic [WORD-1:0]                 addr_i,
  input  logic [WORD-1:0]                 wdata_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            fault_o,
  output logic [1:0]                      faultCode_o,
  output logic [WORD-1:0]                 rdata_o,
  output logic                            busReq_o,
  output logic                            busWe_o,
  output logic [WORD-$clog2(BYTES)-1:0]   busAdr_o,
  output logic [BYTES-1:0]                busBe_o,
  output logic [WORD-1:0]                 busDat_o,
  input  logic [WORD-1:0]                 busDat_i,
  input  logic                            busAck_i
);
  import xm_pkg::*;

  localparam int LW = $clog2(BYTES);
  localparam int CW = $clog2(TIMEOUT);

  mem_state_t      state;
  logic [CW-1:0]   wait_cnt;
  logic            we_q;
  logic            byte_q;
  logic            sext_q;
  logic [WORD-1:0] addr_q;
  logic [WORD-1:0] wdata_q;
  logic [WORD-1:0] rdata_q;
  logic [1:0]      fcode_q;

  logic [BYTES-1:0] lane_be;
  logic [WORD-1:0]  lane_wdat;
  logic [WORD-1:0]  lane_rdat;
  logic             in_bus;

  xm_byte_lane #(.WORD(WORD)) u_lane (
    .lane      (addr_q[LW-1:0]),
    .byte_op   (byte_q),
    .sign_ext  (sext_q),
    .wdata     (wdata_q),
    .bus_rdata (busDat_i),
    .be        (lane_be),
    .wdat      (lane_wdat),
    .rdat      (lane_rdat)
  );

  // Sequencer: accept, alignment check, bus wait/timeout, completion pulses
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fcode_q  <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= write_i;
            byte_q  <= byteOp_i;
            sext_q  <= signExt_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (!byteOp_i && (addr_i[LW-1:0] != '0)) begin
              state   <= FAULT;
              fcode_q <= FAULT_ALIGN;
            end else begin
              state    <= BUS;
              wait_cnt <= '0;
              fcode_q  <= FAULT_NONE;
            end
          end
        end
        BUS: begin
          // An ack on the last permitted wait cycle still completes the access
          if (busAck_i) begin
            state <= DONE;
            if (!we_q) rdata_q <= lane_rdat;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state   <= FAULT;
            fcode_q <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and bus outputs decode straight from state so reset clears them at once
  always_comb begin
    in_bus      = (state == BUS);
    busy_o      = (state != IDLE);
    done_o      = (state == DONE);
    fault_o     = (state == FAULT);
    faultCode_o = fcode_q;
    rdata_o     = rdata_q;
    busReq_o    = in_bus;
    busWe_o     = in_bus & we_q;
    busAdr_o    = in_bus ? addr_q[WORD-1:LW] : '0;
    busBe_o     = in_bus ? lane_be : '0;
    busDat_o    = in_bus ? lane_wdat : '0;
  end

endmodule
